// File: rtl/linear_proj_ctrl.sv
// Sequencer for the Q/K/V multwrap_wbram projection bank: streams input tiles with
// their weight addresses, paces the wrappers on their done flags, and hands off each row block.
module linear_proj_ctrl #(
    parameter int IN_W       = 256,
    parameter int ADDR_W     = 8,
    parameter int IN_TILES   = 4,
    parameter int ROW_BLOCKS = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IN_W-1:0]               in_data,
    output logic                          en,
    output logic                          internal_rst_n,
    output logic                          internal_reset_acc,
    output logic                          w_mat_enb,
    output logic [ADDR_W-1:0]             w_mat_addrb,
    output logic [IN_W-1:0]               in_multi_matmul,
    input  logic                          systolic_finish_all,
    input  logic                          acc_done_all,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(ROW_BLOCKS):0]   out_row,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    localparam int ROW_W  = $clog2(ROW_BLOCKS) + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(IN_TILES - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROW_BLOCKS - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SRST, S_LOAD, S_RUN, S_WAIT_ACC, S_OUT, S_CLR, S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_k;
    logic [ROW_W-1:0]    r_row;
    logic [WAIT_W-1:0]   r_wait;

    logic                r_in_ready, r_en, r_irst_n, r_racc, r_enb;
    logic [ADDR_W-1:0]   r_addr;
    logic [IN_W-1:0]     r_data;
    logic                r_out_valid, r_busy, r_done, r_error;
    logic [ROW_W-1:0]    r_out_row;

    logic w_start_run, w_accept, w_k_inc, w_k_clr, w_row_inc, w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_start_run = 1'b0;
        w_accept    = 1'b0;
        w_k_inc     = 1'b0;
        w_k_clr     = 1'b0;
        w_row_inc   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: if (start) begin
                w_start_run = 1'b1;
                w_next      = S_SRST;
            end
            S_SRST: w_next = S_LOAD;
            S_LOAD: if (in_valid && r_in_ready) begin
                w_accept = 1'b1;
                w_next   = S_RUN;
            end
            // A finish flag on the watchdog's last cycle still counts as progress.
            S_RUN: begin
                if (systolic_finish_all) begin
                    if (r_k == K_LAST) begin
                        w_next = S_WAIT_ACC;
                    end else begin
                        w_k_inc = 1'b1;
                        w_next  = S_LOAD;
                    end
                end else if (r_wait == WAIT_MAX) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_WAIT_ACC: begin
                if (acc_done_all) begin
                    w_next = S_OUT;
                end else if (r_wait == WAIT_MAX) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_OUT: if (out_ready) w_next = S_CLR;
            S_CLR: begin
                w_k_clr = 1'b1;
                if (r_row == ROW_LAST) begin
                    w_next = S_DONE;
                end else begin
                    w_row_inc = 1'b1;
                    w_next    = S_LOAD;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Watchdog restarts on each state entry so every tile gets a full budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= '0;
        end else if (w_next != r_state) begin
            r_wait <= '0;
        end else if (r_state == S_RUN || r_state == S_WAIT_ACC) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k   <= '0;
            r_row <= '0;
        end else begin
            if (w_start_run || w_k_clr) r_k <= '0;
            else if (w_k_inc)           r_k <= r_k + 1'b1;
            if (w_start_run)            r_row <= '0;
            else if (w_row_inc)         r_row <= r_row + 1'b1;
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b0;
            r_en        <= 1'b0;
            r_irst_n    <= 1'b1;
            r_racc      <= 1'b0;
            r_enb       <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_out_valid <= 1'b0;
            r_out_row   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_in_ready  <= (w_next == S_LOAD);
            r_en        <= (w_next == S_RUN) || (w_next == S_WAIT_ACC);
            r_irst_n    <= !((w_next == S_SRST) || w_timeout);
            r_racc      <= (w_next == S_CLR);
            r_enb       <= w_accept;
            r_out_valid <= (w_next == S_OUT);
            r_out_row   <= r_row;
            r_busy      <= (w_next != S_IDLE);
            r_done      <= (w_next == S_DONE);
            if (w_accept) begin
                r_addr <= r_k;
                r_data <= in_data;
            end
            if (w_start_run)    r_error <= 1'b0;
            else if (w_timeout) r_error <= 1'b1;
        end
    end

    assign in_ready           = r_in_ready;
    assign en                 = r_en;
    assign internal_rst_n     = r_irst_n;
    assign internal_reset_acc = r_racc;
    assign w_mat_enb          = r_enb;
    assign w_mat_addrb        = r_addr;
    assign in_multi_matmul    = r_data;
    assign out_valid          = r_out_valid;
    assign out_row            = r_out_row;
    assign busy               = r_busy;
    assign done               = r_done;
    assign error              = r_error;

endmodule

// File: doc/linear_proj_ctrl.md
Name: linear_proj_ctrl

Overview:
Sequencer that drives the bank of multwrap_wbram projection wrappers (Q/K/V heads) in the multi-head attention datapath. It accepts input-activation tiles over a valid/ready stream, broadcasts each tile with the matching weight-BRAM address, and paces the wrappers using their aggregated systolic_finish_all / acc_done_all flags. After each row block it hands the accumulated result to the downstream consumer with a valid/ready handshake, then clears the accumulators.

Parameters:
IN_W, 256, width of one input tile (in_multi_matmul bus)
ADDR_W, 8, weight BRAM port-B address width
IN_TILES, 4, tiles accumulated per row block (accumulation depth); must be 1 to 2^ADDR_W
ROW_BLOCKS, 4, row blocks per run (TOTAL_INPUT_W)
TIMEOUT, 1024, maximum cycles to wait for a wrapper flag before aborting

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run when idle
in_valid  in  1  input tile valid
in_ready  out  1  controller accepts a tile
in_data  in  IN_W  input tile
en  out  1  en_module to all wrappers
internal_rst_n  out  1  wrapper soft reset, active low
internal_reset_acc  out  1  wrapper accumulator clear
w_mat_enb  out  1  weight BRAM read enable
w_mat_addrb  out  ADDR_W  weight BRAM read address
in_multi_matmul  out  IN_W  registered tile broadcast to wrappers
systolic_finish_all  in  1  AND of all wrapper systolic_finish flags
acc_done_all  in  1  AND of all wrapper acc_done flags
out_valid  out  1  row-block result ready in the wrappers
out_ready  in  1  consumer has taken the result
out_row  out  $clog2(ROW_BLOCKS)+1  index of the current row block
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on normal completion
error  out  1  sticky timeout flag; cleared by the next accepted start

Behaviour:
- All outputs are registered. Reset values: internal_rst_n=1, error=0, all other outputs 0, state=IDLE.
- IDLE: on start, clear counters row=0 and k=0, clear error, go to SRST. start is ignored in every state other than IDLE.
- SRST: internal_rst_n=0 for exactly 1 cycle, then go to LOAD.
- LOAD: in_ready=1. On in_valid&&in_ready: latch in_data into in_multi_matmul, assert w_mat_enb=1 for 1 cycle with w_mat_addrb=k, go to RUN.
- RUN: en=1. in_multi_matmul holds its value until the next LOAD acceptance.
  - When systolic_finish_all is sampled high and k<IN_TILES-1: k++ and go to LOAD.
  - When systolic_finish_all is sampled high and k=IN_TILES-1: go to WAIT_ACC.
- WAIT_ACC: en=1. When acc_done_all is sampled high, go to OUT.
- OUT: en=0, out_valid=1, out_row=row. out_valid stays high until out_ready is sampled high, then go to CLR.
- CLR: internal_reset_acc=1 for 1 cycle, k=0.
  - If row=ROW_BLOCKS-1: go to DONE.
  - Otherwise: row++ and go to LOAD.
- DONE: done=1 for 1 cycle, then go to IDLE.
- Latency: from in_valid&&in_ready to the earliest en assertion is 1 cycle.
- Watchdog:
  - A wait counter resets on every state entry and increments each cycle spent in RUN or WAIT_ACC.
  - On reaching TIMEOUT: set error=1, pulse internal_rst_n=0 for 1 cycle, go to IDLE. done is not asserted.
- Simultaneous events:
  - If systolic_finish_all and acc_done_all are both high in RUN on the last tile, go to WAIT_ACC, then OUT on the next cycle (flag still sampled).
  - start arriving in the same cycle as done is ignored.
- Reset mid-operation: asynchronous return to IDLE with the reset values above. Any partial wrapper state is discarded because rst_n also resets the wrappers.
- in_valid is not sampled outside LOAD. Tiles arriving early are back-pressured by in_ready=0.

Test Plan:
- IN_TILES=3, ROW_BLOCKS=2, in_valid held high, finish/accumulate flags return 4 cycles after en rises, out_ready high -> w_mat_addrb sequence 0,1,2,0,1,2; out_valid pulses with out_row=0 then 1; internal_reset_acc pulses twice; exactly one done pulse; busy falls the cycle after done.
- start pulse -> internal_rst_n low for exactly 1 cycle before the first in_ready=1.
- in_valid withheld 10 cycles in LOAD -> en=0 and w_mat_enb=0 throughout; the tile with in_data=0xA5... is accepted on the first in_valid cycle; in_multi_matmul=0xA5... from the next cycle until the following acceptance.
- out_ready low for 7 cycles in OUT -> out_valid stable high for 7 cycles; no internal_reset_acc until the cycle after out_ready is sampled high.
- TIMEOUT=16 and systolic_finish_all never rises -> error=1 after 16 RUN cycles, one internal_rst_n low pulse, return to IDLE, no done; a later start clears error.
- rst_n asserted during WAIT_ACC of row 1 -> all outputs immediately at reset values; after release, a start re-runs from row 0 with addr 0.
